// File: rtl/mem_stage_ext.sv
// MEM pipeline stage: data memory with sub-word access, optional wait states,
// store-data forwarding, Tnew countdown and the MEM/WB pipeline register.
module mem_stage_ext #(
  parameter int unsigned DM_WORDS    = 1024,
  parameter logic [31:0] DM_BASE     = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  mem_op,
  input  logic        reg_we_in,
  input  logic [4:0]  reg_waddr_in,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] fwd_wb_data,
  input  logic        fwd_sel,
  input  logic [31:0] pc_in,
  input  logic [2:0]  tnew_in,
  output logic        stall,
  output logic [2:0]  tnew_mem,
  output logic [4:0]  waddr_mem,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_pc,
  output logic [2:0]  wb_tnew,
  output logic        misalign_err
);

  localparam int unsigned AW     = $clog2(DM_WORDS);
  localparam logic [2:0]  WAIT_L = 3'(WAIT_CYCLES);

  localparam logic [3:0] OP_LW  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LB  = 4'b0100;
  localparam logic [3:0] OP_LBU = 4'b0101;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SB  = 4'b1100;

  logic [31:0]   dm_r [DM_WORDS];
  logic [2:0]    cnt_r;

  logic          is_load_s;
  logic          is_store_s;
  logic          word_op_s;
  logic          half_op_s;
  logic          misalign_s;
  logic          mem_acc_s;
  logic          dm_we_s;
  logic [AW-1:0] idx_s;
  logic [1:0]    lane_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   store_s;
  logic [31:0]   wr_word_s;
  logic [31:0]   ld_data_s;
  logic [15:0]   half_s;
  logic [7:0]    byte_s;

  // Addresses wrap modulo the DM size: bits above the index are dropped.
  assign idx_s     = AW'((alu_out_in - DM_BASE) >> 2);
  assign lane_s    = alu_out_in[1:0];
  assign rd_word_s = dm_r[idx_s];
  assign store_s   = fwd_sel ? fwd_wb_data : store_data_in;

  // Operation decode; unknown codes behave as no memory access.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    word_op_s  = 1'b0;
    half_op_s  = 1'b0;
    case (mem_op)
      OP_LW:          begin is_load_s  = 1'b1; word_op_s = 1'b1; end
      OP_LH, OP_LHU:  begin is_load_s  = 1'b1; half_op_s = 1'b1; end
      OP_LB, OP_LBU:  begin is_load_s  = 1'b1; end
      OP_SW:          begin is_store_s = 1'b1; word_op_s = 1'b1; end
      OP_SH:          begin is_store_s = 1'b1; half_op_s = 1'b1; end
      OP_SB:          begin is_store_s = 1'b1; end
      default:        begin is_load_s  = 1'b0; end
    endcase
  end

  assign misalign_s = (word_op_s & (lane_s != 2'b00)) | (half_op_s & lane_s[0]);
  assign mem_acc_s  = valid_in & (is_load_s | is_store_s);
  assign stall      = mem_acc_s & (cnt_r != WAIT_L);
  assign dm_we_s    = mem_acc_s & is_store_s & ~misalign_s & ~stall;
  assign tnew_mem   = (tnew_in == 3'd0) ? 3'd0 : (tnew_in - 3'd1);
  assign waddr_mem  = reg_waddr_in;

  // Load lane selection and sign/zero extension.
  always_comb begin
    half_s = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    byte_s = rd_word_s[{lane_s, 3'b000} +: 8];
    case (mem_op)
      OP_LH:   ld_data_s = {{16{half_s[15]}}, half_s};
      OP_LHU:  ld_data_s = {16'h0000, half_s};
      OP_LB:   ld_data_s = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  ld_data_s = {24'h000000, byte_s};
      default: ld_data_s = rd_word_s;
    endcase
  end

  // Store merge: unselected lanes keep their current contents.
  always_comb begin
    wr_word_s = rd_word_s;
    case (mem_op)
      OP_SW:   wr_word_s = store_s;
      OP_SH:   wr_word_s[{lane_s[1], 4'b0000} +: 16] = store_s[15:0];
      OP_SB:   wr_word_s[{lane_s, 3'b000} +: 8] = store_s[7:0];
      default: wr_word_s = rd_word_s;
    endcase
  end

  // Data memory, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DM_WORDS); i++) begin
        dm_r[i] <= 32'h0000_0000;
      end
    end else if (dm_we_s) begin
      dm_r[idx_s] <= wr_word_s;
    end
  end

  // Wait-state counter: counts stall cycles, returns to 0 on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 3'd0;
    end else if (stall) begin
      cnt_r <= cnt_r + 3'd1;
    end else begin
      cnt_r <= 3'd0;
    end
  end

  // MEM/WB register: bubble while stalled or empty, else commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_waddr     <= 5'd0;
      wb_wdata     <= 32'h0000_0000;
      wb_pc        <= RESET_PC;
      wb_tnew      <= 3'd0;
      misalign_err <= 1'b0;
    end else if (stall | ~valid_in) begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_tnew      <= 3'd0;
      misalign_err <= 1'b0;
    end else begin
      wb_valid     <= 1'b1;
      wb_we        <= reg_we_in & ~(mem_acc_s & misalign_s);
      wb_waddr     <= reg_waddr_in;
      wb_wdata     <= (mem_acc_s & is_load_s) ? ld_data_s : alu_out_in;
      wb_pc        <= pc_in;
      wb_tnew      <= tnew_mem;
      misalign_err <= mem_acc_s & misalign_s;
    end
  end

endmodule

// File: tb/tb_mem_stage_ext.sv
// Randomized and directed bench for mem_stage_ext: one instance without wait
// states, one with three, both checked against a byte-level memory model.
module tb_mem_stage_ext;

  localparam int NW = 64;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       reset = 2'b11;
  logic [1:0]       valid_in = '0;
  logic [1:0][3:0]  mem_op = '0;
  logic [1:0]       reg_we_in = '0;
  logic [1:0][4:0]  reg_waddr_in = '0;
  logic [1:0][31:0] alu_out_in = '0;
  logic [1:0][31:0] store_data_in = '0;
  logic [1:0][31:0] fwd_wb_data = '0;
  logic [1:0]       fwd_sel = '0;
  logic [1:0][31:0] pc_in = '0;
  logic [1:0][2:0]  tnew_in = '0;
  logic [1:0]       stall;
  logic [1:0][2:0]  tnew_mem;
  logic [1:0][4:0]  waddr_mem;
  logic [1:0]       wb_valid;
  logic [1:0]       wb_we;
  logic [1:0][4:0]  wb_waddr;
  logic [1:0][31:0] wb_wdata;
  logic [1:0][31:0] wb_pc;
  logic [1:0][2:0]  wb_tnew;
  logic [1:0]       misalign_err;

  mem_stage_ext #(.DM_WORDS(NW), .DM_BASE(BASE0), .WAIT_CYCLES(0), .RESET_PC(RST_PC)) dut0 (
    .clk(clk), .reset(reset[0]), .valid_in(valid_in[0]), .mem_op(mem_op[0]),
    .reg_we_in(reg_we_in[0]), .reg_waddr_in(reg_waddr_in[0]), .alu_out_in(alu_out_in[0]),
    .store_data_in(store_data_in[0]), .fwd_wb_data(fwd_wb_data[0]), .fwd_sel(fwd_sel[0]),
    .pc_in(pc_in[0]), .tnew_in(tnew_in[0]), .stall(stall[0]), .tnew_mem(tnew_mem[0]),
    .waddr_mem(waddr_mem[0]), .wb_valid(wb_valid[0]), .wb_we(wb_we[0]), .wb_waddr(wb_waddr[0]),
    .wb_wdata(wb_wdata[0]), .wb_pc(wb_pc[0]), .wb_tnew(wb_tnew[0]), .misalign_err(misalign_err[0]));

  mem_stage_ext #(.DM_WORDS(NW), .DM_BASE(BASE1), .WAIT_CYCLES(3), .RESET_PC(RST_PC)) dut3 (
    .clk(clk), .reset(reset[1]), .valid_in(valid_in[1]), .mem_op(mem_op[1]),
    .reg_we_in(reg_we_in[1]), .reg_waddr_in(reg_waddr_in[1]), .alu_out_in(alu_out_in[1]),
    .store_data_in(store_data_in[1]), .fwd_wb_data(fwd_wb_data[1]), .fwd_sel(fwd_sel[1]),
    .pc_in(pc_in[1]), .tnew_in(tnew_in[1]), .stall(stall[1]), .tnew_mem(tnew_mem[1]),
    .waddr_mem(waddr_mem[1]), .wb_valid(wb_valid[1]), .wb_we(wb_we[1]), .wb_waddr(wb_waddr[1]),
    .wb_wdata(wb_wdata[1]), .wb_pc(wb_pc[1]), .wb_tnew(wb_tnew[1]), .misalign_err(misalign_err[1]));

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] mdl_mem [2][NW];
  logic [31:0] last_pc [2];
  logic [31:0] pc_ctr  [2];
  logic [31:0] last_wd;

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference memory: byte lanes computed with plain shifts and masks.
  task automatic model_access(input int d, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdat, output logic mis, output logic [31:0] ld);
    int unsigned wi, lane, sh;
    logic [31:0] w, h, b, mask;
    wi   = ((addr - base_of(d)) >> 2) % NW;
    lane = addr % 4;
    sh   = lane * 8;
    w    = mdl_mem[d][wi];
    h    = (w >> sh) & 32'h0000_FFFF;
    b    = (w >> sh) & 32'h0000_00FF;
    mis  = 1'b0;
    ld   = 32'h0;
    case (op)
      4'h1: begin mis = (lane != 0); ld = w; end
      4'h2: begin mis = (lane % 2 != 0); ld = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h; end
      4'h3: begin mis = (lane % 2 != 0); ld = h; end
      4'h4: ld = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      4'h5: ld = b;
      4'h9: begin mis = (lane != 0); w = sdat; end
      4'hA: begin
        mis  = (lane % 2 != 0);
        mask = 32'h0000_FFFF << sh;
        w    = (w & ~mask) | ((sdat & 32'h0000_FFFF) << sh);
      end
      4'hC: begin
        mask = 32'h0000_00FF << sh;
        w    = (w & ~mask) | ((sdat & 32'h0000_00FF) << sh);
      end
      default: ld = 32'h0;
    endcase
    if (!mis) mdl_mem[d][wi] = w;
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    reset[d] = 1'b1;
    valid_in[d] = 1'b0;
    @(negedge clk);
    reset[d] = 1'b0;
    for (int i = 0; i < NW; i++) mdl_mem[d][i] = 32'h0;
    last_pc[d] = RST_PC;
    #1;
    check_eq("rst_valid", {31'd0, wb_valid[d]}, 32'd0);
    check_eq("rst_we", {31'd0, wb_we[d]}, 32'd0);
    check_eq("rst_waddr", {27'd0, wb_waddr[d]}, 32'd0);
    check_eq("rst_wdata", wb_wdata[d], 32'd0);
    check_eq("rst_pc", wb_pc[d], RST_PC);
    check_eq("rst_tnew", {29'd0, wb_tnew[d]}, 32'd0);
    check_eq("rst_mis", {31'd0, misalign_err[d]}, 32'd0);
    check_eq("rst_stall", {31'd0, stall[d]}, 32'd0);
  endtask

  // One instruction through MEM, checking stalls, bubbles and the WB result.
  task automatic xact(input int d, input logic v, input logic [3:0] op, input logic we,
                      input logic [4:0] wa, input logic [31:0] addr, input logic [31:0] sd,
                      input logic [31:0] fw, input logic fs, input logic [2:0] tn);
    logic is_ld, is_st, acc, mis;
    logic [31:0] ld, exp_wd;
    logic [2:0] etn;
    int nw;
    pc_ctr[d] = pc_ctr[d] + 32'd4;
    @(negedge clk);
    valid_in[d] = v; mem_op[d] = op; reg_we_in[d] = we; reg_waddr_in[d] = wa;
    alu_out_in[d] = addr; store_data_in[d] = sd; fwd_wb_data[d] = fw; fwd_sel[d] = fs;
    pc_in[d] = pc_ctr[d]; tnew_in[d] = tn;
    is_ld = op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    is_st = op inside {4'h9, 4'hA, 4'hC};
    acc   = v && (is_ld || is_st);
    mis   = 1'b0;
    ld    = 32'h0;
    if (acc) model_access(d, op, addr, fs ? fw : sd, mis, ld);
    etn = (tn == 3'd0) ? 3'd0 : tn - 3'd1;
    nw  = acc ? wait_of(d) : 0;
    #1;
    check_eq("tnew_mem", {29'd0, tnew_mem[d]}, {29'd0, etn});
    check_eq("waddr_mem", {27'd0, waddr_mem[d]}, {27'd0, wa});
    for (int k = 0; k < nw; k++) begin
      check_eq("stall_hi", {31'd0, stall[d]}, 32'd1);
      @(posedge clk); #1;
      check_eq("bub_valid", {31'd0, wb_valid[d]}, 32'd0);
      check_eq("bub_tnew", {29'd0, wb_tnew[d]}, 32'd0);
      check_eq("bub_pc", wb_pc[d], last_pc[d]);
    end
    check_eq("stall_lo", {31'd0, stall[d]}, 32'd0);
    @(posedge clk); #1;
    last_wd = wb_wdata[d];
    if (v) begin
      last_pc[d] = pc_ctr[d];
      exp_wd = (acc && is_ld) ? ld : addr;
      check_eq("wb_valid", {31'd0, wb_valid[d]}, 32'd1);
      check_eq("wb_we", {31'd0, wb_we[d]}, {31'd0, we & ~mis});
      check_eq("wb_waddr", {27'd0, wb_waddr[d]}, {27'd0, wa});
      check_eq("wb_pc", wb_pc[d], pc_ctr[d]);
      check_eq("wb_tnew", {29'd0, wb_tnew[d]}, {29'd0, etn});
      check_eq("misalign", {31'd0, misalign_err[d]}, {31'd0, mis});
      if (!mis) check_eq("wb_wdata", wb_wdata[d], exp_wd);
    end else begin
      check_eq("idle_valid", {31'd0, wb_valid[d]}, 32'd0);
      check_eq("idle_we", {31'd0, wb_we[d]}, 32'd0);
      check_eq("idle_tnew", {29'd0, wb_tnew[d]}, 32'd0);
      check_eq("idle_mis", {31'd0, misalign_err[d]}, 32'd0);
      check_eq("idle_pc", wb_pc[d], last_pc[d]);
    end
  endtask

  task automatic xl(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd);
    xact(d, 1'b1, op, op[3] ? 1'b0 : 1'b1, 5'd7, base_of(d) + a, sd, 32'h0, 1'b0, 3'd2);
  endtask

  initial begin
    pc_ctr[0] = 32'h0000_0400;
    pc_ctr[1] = 32'h0000_0800;
    do_reset(0);
    do_reset(1);

    // Directed sub-word cases without wait states.
    xl(0, 4'h9, 32'h10, 32'h1234_5678);
    xl(0, 4'h5, 32'h13, 32'h0); check_eq("tp_lbu", last_wd, 32'h0000_0012);
    xl(0, 4'h4, 32'h13, 32'h0); check_eq("tp_lb", last_wd, 32'h0000_0012);
    xl(0, 4'h3, 32'h12, 32'h0); check_eq("tp_lhu", last_wd, 32'h0000_1234);
    xl(0, 4'h2, 32'h12, 32'h0); check_eq("tp_lh", last_wd, 32'h0000_1234);
    xl(0, 4'h9, 32'h10, 32'hF0F0_8080);
    xl(0, 4'h4, 32'h10, 32'h0); check_eq("tp_lb_neg", last_wd, 32'hFFFF_FF80);
    xl(0, 4'h3, 32'h12, 32'h0); check_eq("tp_lhu_hi", last_wd, 32'h0000_F0F0);
    xl(0, 4'h9, 32'h20, 32'h1122_3344);
    xl(0, 4'hC, 32'h21, 32'h0000_00AB);
    xl(0, 4'h1, 32'h20, 32'h0); check_eq("tp_sb", last_wd, 32'h1122_AB44);
    xl(0, 4'hA, 32'h22, 32'h0000_BEEF);
    xl(0, 4'h1, 32'h20, 32'h0); check_eq("tp_sh", last_wd, 32'hBEEF_AB44);
    xl(0, 4'h9, 32'h04, 32'h5555_AAAA);
    xl(0, 4'h1, 32'h06, 32'h0);
    xl(0, 4'hA, 32'h05, 32'hFFFF_FFFF);
    xl(0, 4'h1, 32'h04, 32'h0); check_eq("tp_mis_keep", last_wd, 32'h5555_AAAA);
    xact(0, 1'b1, 4'h9, 1'b0, 5'd0, 32'h30, 32'h0, 32'hCAFE_BABE, 1'b1, 3'd2);
    xl(0, 4'h1, 32'h30, 32'h0); check_eq("tp_fwd", last_wd, 32'hCAFE_BABE);
    xact(0, 1'b1, 4'h0, 1'b1, 5'd3, 32'h0000_0099, 32'h0, 32'h0, 1'b0, 3'd0);
    xact(0, 1'b0, 4'h1, 1'b1, 5'd4, 32'h10, 32'h0, 32'h0, 1'b0, 3'd2);

    // Wait-state instance: lw followed by addu, then back-to-back store/load.
    xl(1, 4'h9, 32'h40, 32'h8765_4321);
    xl(1, 4'h1, 32'h40, 32'h0);
    xact(1, 1'b1, 4'h0, 1'b1, 5'd9, 32'h0000_0042, 32'h0, 32'h0, 1'b0, 3'd1);
    xl(1, 4'h5, 32'h43, 32'h0);
    xl(1, 4'h1, 32'h42, 32'h0);

    // Reset in the second cycle of a store drops the store.
    @(negedge clk);
    valid_in[1] = 1'b1; mem_op[1] = 4'h9; reg_we_in[1] = 1'b0;
    alu_out_in[1] = BASE1 + 32'h50; store_data_in[1] = 32'hDEAD_BEEF; fwd_sel[1] = 1'b0;
    #1 check_eq("rs_stall0", {31'd0, stall[1]}, 32'd1);
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0; valid_in[1] = 1'b0;
    for (int i = 0; i < NW; i++) mdl_mem[1][i] = 32'h0;
    last_pc[1] = RST_PC;
    #1;
    check_eq("rs_stall", {31'd0, stall[1]}, 32'd0);
    check_eq("rs_pc", wb_pc[1], RST_PC);
    xl(1, 4'h1, 32'h50, 32'h0); check_eq("rs_word", last_wd, 32'h0);

    // Randomized mix on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        logic [3:0] op;
        case ($urandom_range(0, 11))
          0: op = 4'h0;  1: op = 4'h1;  2: op = 4'h2;  3: op = 4'h3;
          4: op = 4'h4;  5: op = 4'h5;  6: op = 4'h9;  7: op = 4'hA;
          8: op = 4'hC;  9: op = 4'h7;  10: op = 4'hF; default: op = 4'h9;
        endcase
        xact(d, ($urandom_range(0, 7) != 0), op, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), base_of(d) + 32'($urandom_range(0, 511)),
             $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage_ext.md
# mem_stage_ext

Parametrised memory pipeline stage that sits between EX and WB. It adds three things to the word-only stage: sub-word loads and stores with sign or zero extension, a configurable DM depth and base address, and optional wait-state latency with an upstream stall handshake. It holds the data memory, the store-data forwarding mux from WB, the Tnew countdown for the hazard unit, and the MEM/WB pipeline register.

## Interface
Parameters:
- DM_WORDS, 1024: DM depth in 32-bit words; power of two, 16..65536.
- DM_BASE, 32'h0000_0000: byte address of DM word 0.
- WAIT_CYCLES, 0: extra cycles every load or store occupies; range 0..7.
- RESET_PC, 32'h0000_3000: reset value of wb_pc.

Ports:
- clk  in  1  stage clock.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- valid_in  in  1  EX/MEM holds a live instruction.
- mem_op  in  4  memory operation: 0000 none, 0001 lw, 0010 lh, 0011 lhu, 0100 lb, 0101 lbu, 1001 sw, 1010 sh, 1100 sb; other codes are treated as none.
- reg_we_in  in  1  instruction writes the GPR file.
- reg_waddr_in  in  5  GPR destination.
- alu_out_in  in  32  effective address, or ALU result for non-memory instructions.
- store_data_in  in  32  store data from EX.
- fwd_wb_data  in  32  WB result for store-data forwarding.
- fwd_sel  in  1  1 = store data comes from fwd_wb_data.
- pc_in  in  32  instruction PC.
- tnew_in  in  3  Tnew on entry to MEM.
- stall  out  1  combinational; upstream holds EX/MEM stable while this is high.
- tnew_mem  out  3  combinational: tnew_in−1, saturating at 0.
- waddr_mem  out  5  combinational: reg_waddr_in, for the hazard unit.
- wb_valid, wb_we  out  1 each  registered.
- wb_waddr  out  5  registered.
- wb_wdata, wb_pc  out  32 each  registered.
- wb_tnew  out  3  registered tnew_mem.
- misalign_err  out  1  registered one-cycle pulse.

## Operation
- mem_op ≠ none and valid_in make a memory access.
- Word index = (alu_out_in − DM_BASE)[2 +: log2(DM_WORDS)]. Bits above that range are ignored, so addresses wrap.
- Byte lane = alu_out_in[1:0].
- Alignment rules:
  - lw/sw need lane 0.
  - lh/lhu/sh need lane[0] = 0.
  - Byte ops are always aligned.
- A misaligned access at commit:
  - No DM write.
  - wb_we = 0 and misalign_err = 1 for one cycle.
  - wb_valid still 1, wb_pc = pc_in.
- Store data = fwd_sel ? fwd_wb_data : store_data_in, sampled in the commit cycle.
- Store byte enables:
  - sw writes all 4 lanes.
  - sh writes lanes {1,0} or {3,2}, using data[15:0].
  - sb writes one lane, using data[7:0].
  - Unselected lanes are unchanged.
- Loads read DM asynchronously. The selected lane or half-word is sign-extended (lh, lb) or zero-extended (lhu, lbu).
- wb_wdata selection:
  - Loads: the extended load data.
  - All other instructions: alu_out_in.
- wb_we = valid_in & reg_we_in & ~misaligned. A reg_waddr_in of 0 still registers; the GPR file ignores writes to $0.
- Wait-state counter cnt (0..WAIT_CYCLES):
  - IDLE is cnt = 0; WAIT is cnt > 0.
  - stall = memory access & (cnt ≠ WAIT_CYCLES).
  - While stall is high: cnt increments, DM is unchanged, and the WB register loads a bubble (wb_valid = 0, wb_we = 0, wb_tnew = 0; wb_pc holds).
  - The commit cycle is cnt = WAIT_CYCLES: the DM write and the WB register load happen on that edge, then cnt returns to 0.
  - Non-memory instructions and invalid slots commit in the cycle they are presented, with no stall.
- Upstream must not change inputs while stall is high. Behaviour under changed inputs is undefined, but DM is written at most once per commit.

## Timing
- Reset values:
  - wb_valid 0, wb_we 0, wb_waddr 0, wb_wdata 0, wb_tnew 0, misalign_err 0.
  - wb_pc = RESET_PC, cnt 0.
  - All DM words are cleared to 0 on the same edge.
- WAIT_CYCLES = 0: one-cycle stage, and stall is never asserted.
- WAIT_CYCLES = N: each memory access spends N+1 cycles in MEM, with stall high for the first N. Results appear at WB on the edge after the final cycle.
- Back-to-back memory accesses: each starts from cnt = 0, with no idle cycle between them.
- A store followed by a load to the same word: the load sees the new data, because the write commits on the store's commit edge.
- Reset during WAIT: cnt returns to 0 and no DM write occurs. An in-flight store is lost.
- valid_in = 0: the WB register loads a bubble and tnew_mem is still driven.

## Test plan
- WAIT_CYCLES=0. sw 0x12345678 to addr 0x10, then lbu/lb/lhu/lh at 0x13/0x13/0x12/0x12 → wb_wdata = 0x12, 0x12, 0x1234, 0x1234. Repeat with word 0xF0F08080: lb at 0x10 → 0xFFFFFF80; lhu at 0x12 → 0xF0F0.
- sb 0xAB to 0x21 over word 0x11223344 → word becomes 0x1122AB44; sh 0xBEEF to 0x22 → 0xBEEFAB44.
- lw at 0x06 and sh at 0x05 → misalign_err pulses for one cycle, wb_we 0, DM unchanged.
- WAIT_CYCLES=3, lw followed by addu → stall high for 3 cycles; three bubble cycles at WB (wb_valid 0); the lw result on the 4th edge; addu reaches WB on the following edge.
- fwd_sel=1 with fwd_wb_data 0xCAFEBABE and store_data_in 0 on sw → DM holds 0xCAFEBABE. tnew_in 2 → tnew_mem 1; tnew_in 0 → 0.
- WAIT_CYCLES=3: assert reset in cycle 2 of a sw → the word is still 0, wb_pc = 0x00003000, stall drops on the next cycle.
